obstacle_field: RTL and testbench
=================================

# obstacle_field

Multi-obstacle game engine for the falling-obstacle dodge game: keeps up to N_OBST obstacles on screen, spawns them at pseudo-random x positions, moves them once per game tick, detects collision with the player box, and keeps score, best score and game state. It sits between the player controller (player position in) and the pixel colour mux (per-pixel obstacle hit out). It replaces the single-obstacle controller and the ad-hoc spawn/score logic in the top level.

## Interface
- N_OBST, 4: obstacle slots.
- OBST_W / OBST_H, 32 / 32: obstacle box size, px.
- PLAYER_W / PLAYER_H, 32 / 32: player box size, px.
- SPAWN_DELAY, 60: ticks between spawn attempts, ≥1.
- STEP_INIT / STEP_MAX, 2 / 8: initial and maximum fall step, px per tick.
- SPEEDUP_EVERY, 10: points per +1 step.
- SCORE_W, 7: score width.
- LFSR_SEED, 10'h2A5: LFSR reset value, non-zero.
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous, active-high.
- tick  in  1  one-cycle game-update pulse, once per frame.
- start  in  1  start/restart request, level-sampled.
- player_x, player_y  in  10  player top-left.
- pix_x, pix_y  in  10  pixel being queried (VGA next_x/next_y).
- obstacle_drawing  out  1  pixel lies inside an active obstacle.
- playing  out  1  state == PLAY.
- game_over  out  1  state == OVER.
- score, max_score  out  SCORE_W  current and best score.
- obst_valid  out  N_OBST  slot-active flags.

## Operation
- FSM states: IDLE, PLAY, OVER.
  - IDLE→PLAY on start.
  - PLAY→OVER on collision.
  - OVER→PLAY on start.
- Entering PLAY clears all slots, score, spawn timer, and sets step=STEP_INIT. max_score is kept.
- Per tick in PLAY:
  - Spawn timer increments. At SPAWN_DELAY-1 it returns to 0 and loads the lowest-index free slot with y=0 and x=r, where r is the LFSR value and r ≥ 608 gives x=r-608 (SCREEN_W-OBST_W=608).
  - No free slot: the spawn is skipped and the timer still wraps.
  - Every valid slot: y += step.
  - A slot with y+step ≥ 480 is cleared instead of moved and scores +1.
  - Multiple exits on one tick add their count.
  - score saturates at 2^SCORE_W-1.
  - max_score = max(max_score, score) is updated on the same cycle.
  - step = min(STEP_MAX, STEP_INIT + score/SPEEDUP_EVERY). It is recomputed when score changes, implemented as a down-counter, not a divider.
- A slot spawned on a tick is not moved on that tick.
- Collision, evaluated every cycle in PLAY on registered positions, 11-bit compares:
  - ox < px+PLAYER_W
  - px < ox+OBST_W
  - oy < py+PLAYER_H
  - py < oy+OBST_H
- Collision and tick in the same cycle: collision wins; no move, spawn or score that cycle.
- In OVER, obstacles freeze and stay drawn. In IDLE, none are drawn.
- LFSR: 10-bit Fibonacci, x^10+x^7+1, advances every clock in all states.
- obstacle_drawing = OR over valid slots of (ox ≤ pix_x < ox+OBST_W) and (oy ≤ pix_y < oy+OBST_H).
- Ignored inputs: tick outside PLAY; start in PLAY.

## Timing
- Reset values: state IDLE, all slots invalid, positions 0, score 0, max_score 0, step STEP_INIT, timer 0, LFSR LFSR_SEED, all outputs 0.
- reset overrides start and tick.
- All outputs are registered.
- obstacle_drawing latency: 1 cycle from pix_x/pix_y.
- State change latency: 1 cycle after start or collision. game_over rises the cycle after the overlapping positions are registered.
- Slot and score updates are visible the cycle after tick.
- Reset mid-game: the next cycle is in IDLE with max_score cleared.

## Structure
- Package game_pkg holds:
  - SCREEN_W=640, SCREEN_H=480.
  - State enum: IDLE=2'd0, PLAY=2'd1, OVER=2'd2.
  - Obstacle slot struct: valid, x[9:0], y[9:0].
- Sub-module lfsr10 (clk, reset, seed, value[9:0]) holds the LFSR. Everything else is in obstacle_field using per-slot generate loops.

## Test plan
- Reset, start=1 one cycle → playing=1 next cycle, score=0, obst_valid=0.
- SPAWN_DELAY=3, 3 ticks → obst_valid=0001, slot0 y=0, x<608. Next tick → y=2.
- Obstacle reaches y=478 with step 2, tick → slot cleared, score=1, max_score=1.
- Player at (100,440), obstacle at x=100 falling → game_over=1 one cycle after overlap. Further ticks leave positions unchanged. start → PLAY with score 0, max_score kept.
- All 4 slots full at spawn time → no new slot, timer back to 0. pix=(ox+31, oy+31) → obstacle_drawing=1; pix=(ox+32, oy) → 0.
- SPEEDUP_EVERY=2, score reaches 2 → step=3. Score driven past 127 → stays 127.

Source files
------------

// File: rtl/obstacle_field_pkg.sv
// Shared types and screen geometry for the falling-obstacle game engine.
package game_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [9:0] x;
    logic [9:0] y;
  } slot_t;

  // Two 1-D spans [a, a+a_len) and [b, b+b_len) intersect; 11 bits so sums never wrap.
  function automatic logic span_overlap(input logic [10:0] a, input logic [10:0] a_len,
                                        input logic [10:0] b, input logic [10:0] b_len);
    return (a < b + b_len) && (b < a + a_len);
  endfunction

  function automatic logic in_span(input logic [10:0] p, input logic [10:0] lo,
                                   input logic [10:0] len);
    return (p >= lo) && (p < lo + len);
  endfunction

endpackage

// File: rtl/obstacle_field_if.sv
// Player/pixel inputs and game status outputs of the obstacle engine.
interface obstacle_field_if #(
  parameter int N_OBST  = 4,
  parameter int SCORE_W = 7
);
  logic               tick;
  logic               start;
  logic [9:0]         player_x;
  logic [9:0]         player_y;
  logic [9:0]         pix_x;
  logic [9:0]         pix_y;
  logic               obstacle_drawing;
  logic               playing;
  logic               game_over;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] max_score;
  logic [N_OBST-1:0]  obst_valid;

  modport master (
    output tick, start, player_x, player_y, pix_x, pix_y,
    input  obstacle_drawing, playing, game_over, score, max_score, obst_valid
  );

  modport slave (
    input  tick, start, player_x, player_y, pix_x, pix_y,
    output obstacle_drawing, playing, game_over, score, max_score, obst_valid
  );
endinterface

// File: rtl/obstacle_field_lfsr10.sv
// Free-running 10-bit Fibonacci LFSR (x^10 + x^7 + 1) used for spawn x positions.
module lfsr10 (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] seed,
  output logic [9:0] value
);
  logic [9:0] value_q;

  // Shift every clock; feedback from stages 10 and 7.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= seed;
    end else begin
      value_q <= {value_q[8:0], value_q[9] ^ value_q[6]};
    end
  end

  assign value = value_q;
endmodule

// File: rtl/obstacle_field.sv
// Multi-obstacle game engine: spawn/move/score on each tick, player collision,
// score/best-score tracking and a registered per-pixel obstacle hit.
module obstacle_field
  import game_pkg::*;
#(
  parameter int         N_OBST        = 4,
  parameter int         OBST_W        = 32,
  parameter int         OBST_H        = 32,
  parameter int         PLAYER_W      = 32,
  parameter int         PLAYER_H      = 32,
  parameter int         SPAWN_DELAY   = 60,
  parameter int         STEP_INIT     = 2,
  parameter int         STEP_MAX      = 8,
  parameter int         SPEEDUP_EVERY = 10,
  parameter int         SCORE_W       = 7,
  parameter logic [9:0] LFSR_SEED     = 10'h2A5
) (
  input logic             CLOCK_50,
  input logic             reset,
  obstacle_field_if.slave bus
);
  localparam int TW     = (SPAWN_DELAY > 1) ? $clog2(SPAWN_DELAY) : 1;
  localparam int SPD_W  = $clog2(SPEEDUP_EVERY + 1);
  localparam int STEP_W = $clog2(STEP_MAX + 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [9:0]         X_SPAN    = 10'(SCREEN_W - OBST_W);

  state_t             state_q, state_d;
  slot_t              slot_q [N_OBST];
  slot_t              slot_d [N_OBST];
  logic [TW-1:0]      timer_q, timer_d;
  logic [SCORE_W-1:0] score_q, score_d, max_q, max_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [SPD_W-1:0]   spd_q, spd_d;
  logic               playing_q, over_q, draw_q;
  logic [N_OBST-1:0]  col_s, pix_s, exit_s, valid_s;
  logic [9:0]         lfsr_s, spawn_x_s;
  logic               spawn_s, taken_s;

  lfsr10 u_lfsr (
    .clk   (CLOCK_50),
    .reset (reset),
    .seed  (LFSR_SEED),
    .value (lfsr_s)
  );

  for (genvar g = 0; g < N_OBST; g++) begin : g_slot
    logic [10:0] ox_s, oy_s;
    assign ox_s       = {1'b0, slot_q[g].x};
    assign oy_s       = {1'b0, slot_q[g].y};
    assign valid_s[g] = slot_q[g].valid;
    assign col_s[g]   = slot_q[g].valid
                      && span_overlap(ox_s, 11'(OBST_W), {1'b0, bus.player_x}, 11'(PLAYER_W))
                      && span_overlap(oy_s, 11'(OBST_H), {1'b0, bus.player_y}, 11'(PLAYER_H));
    assign pix_s[g]   = slot_q[g].valid
                      && in_span({1'b0, bus.pix_x}, ox_s, 11'(OBST_W))
                      && in_span({1'b0, bus.pix_y}, oy_s, 11'(OBST_H));
    assign exit_s[g]  = slot_q[g].valid && ((oy_s + 11'(step_q)) >= 11'(SCREEN_H));
  end

  assign spawn_s   = (timer_q == TW'(SPAWN_DELAY - 1));
  assign spawn_x_s = (lfsr_s >= X_SPAN) ? (lfsr_s - X_SPAN) : lfsr_s;
  assign max_d     = (score_d > max_q) ? score_d : max_q;

  // Next state: FSM plus tick update; step tracks score/SPEEDUP_EVERY via a down-counter.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    timer_d = timer_q;
    score_d = score_q;
    step_d  = step_q;
    spd_d   = spd_q;
    taken_s = 1'b0;
    case (state_q)
      IDLE, OVER: begin
        if (bus.start) begin
          state_d = PLAY;
          for (int i = 0; i < N_OBST; i++) begin
            slot_d[i] = '{valid: 1'b0, x: 10'd0, y: 10'd0};
          end
          timer_d = {TW{1'b0}};
          score_d = {SCORE_W{1'b0}};
          step_d  = STEP_W'(STEP_INIT);
          spd_d   = SPD_W'(SPEEDUP_EVERY);
        end else begin
          state_d = state_q;
        end
      end
      PLAY: begin
        if (|col_s) begin
          state_d = OVER;
        end else if (bus.tick) begin
          timer_d = spawn_s ? {TW{1'b0}} : timer_q + 1'b1;
          for (int i = 0; i < N_OBST; i++) begin
            if (exit_s[i]) begin
              slot_d[i].valid = 1'b0;
              if (score_d != SCORE_MAX) begin
                score_d = score_d + 1'b1;
                if (spd_d == SPD_W'(1)) begin
                  spd_d  = SPD_W'(SPEEDUP_EVERY);
                  step_d = (step_d < STEP_W'(STEP_MAX)) ? step_d + 1'b1 : step_d;
                end else begin
                  spd_d = spd_d - 1'b1;
                end
              end else begin
                score_d = score_d;
              end
            end else if (slot_q[i].valid) begin
              slot_d[i].y = slot_q[i].y + 10'(step_q);
            end else begin
              slot_d[i] = slot_q[i];
            end
          end
          // Free slots are judged before this tick, so a slot just cleared is not reused.
          for (int i = 0; i < N_OBST; i++) begin
            if (spawn_s && !slot_q[i].valid && !taken_s) begin
              slot_d[i] = '{valid: 1'b1, x: spawn_x_s, y: 10'd0};
              taken_s   = 1'b1;
            end else begin
              taken_s = taken_s;
            end
          end
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Game registers and registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= IDLE;
      for (int i = 0; i < N_OBST; i++) begin
        slot_q[i] <= '{valid: 1'b0, x: 10'd0, y: 10'd0};
      end
      timer_q   <= {TW{1'b0}};
      score_q   <= {SCORE_W{1'b0}};
      max_q     <= {SCORE_W{1'b0}};
      step_q    <= STEP_W'(STEP_INIT);
      spd_q     <= SPD_W'(SPEEDUP_EVERY);
      playing_q <= 1'b0;
      over_q    <= 1'b0;
      draw_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      timer_q   <= timer_d;
      score_q   <= score_d;
      max_q     <= max_d;
      step_q    <= step_d;
      spd_q     <= spd_d;
      playing_q <= (state_d == PLAY);
      over_q    <= (state_d == OVER);
      draw_q    <= (state_q != IDLE) && (|pix_s);
    end
  end

  assign bus.obstacle_drawing = draw_q;
  assign bus.playing          = playing_q;
  assign bus.game_over        = over_q;
  assign bus.score            = score_q;
  assign bus.max_score        = max_q;
  assign bus.obst_valid       = valid_s;
endmodule

// File: tb/tb_obstacle_field.sv
// Scoreboard bench for obstacle_field: a cycle model pushes expected outputs, a monitor compares them.
module tb_obstacle_field;
  localparam int N = 4, OW = 32, OH = 32, PW = 32, PH = 32;
  localparam int SD = 3, SINIT = 2, SMAX = 8, SE = 2, SW = 7;
  localparam int SCORE_TOP = 127;
  localparam logic [9:0] SEED = 10'h2A5;

  typedef struct {
    int playing; int over; int score; int maxs; int valid; int draw;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  obstacle_field_if #(.N_OBST(N), .SCORE_W(SW)) bus ();

  obstacle_field #(
    .N_OBST(N), .OBST_W(OW), .OBST_H(OH), .PLAYER_W(PW), .PLAYER_H(PH),
    .SPAWN_DELAY(SD), .STEP_INIT(SINIT), .STEP_MAX(SMAX), .SPEEDUP_EVERY(SE),
    .SCORE_W(SW), .LFSR_SEED(SEED)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0, passed = 0, failed = 0;

  // Model state: 0 idle, 1 play, 2 over
  int         m_state, m_score, m_max, m_timer;
  int         m_v [N];
  int         m_x [N];
  int         m_y [N];
  logic [9:0] m_lfsr;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act == expv) passed++;
    else begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("playing",    int'(bus.playing),          mon_e.playing);
      chk("game_over",  int'(bus.game_over),        mon_e.over);
      chk("score",      int'(bus.score),            mon_e.score);
      chk("max_score",  int'(bus.max_score),        mon_e.maxs);
      chk("obst_valid", int'(bus.obst_valid),       mon_e.valid);
      chk("drawing",    int'(bus.obstacle_drawing), mon_e.draw);
    end
  end

  // Drive one clock cycle of inputs, advance the model, queue the outputs expected next cycle.
  task automatic cyc(input bit r, input bit t, input bit s);
    exp_t e;
    bit col, draw, spawn;
    int stp, fi, add, rv, px, py, qx, qy;
    reset = r; bus.tick = t; bus.start = s;
    px = int'(bus.player_x); py = int'(bus.player_y);
    qx = int'(bus.pix_x);    qy = int'(bus.pix_y);
    col = 0; draw = 0;
    for (int i = 0; i < N; i++) begin
      if (m_v[i] != 0) begin
        if (m_x[i] < px + PW && px < m_x[i] + OW && m_y[i] < py + PH && py < m_y[i] + OH) col = 1;
        if (qx >= m_x[i] && qx < m_x[i] + OW && qy >= m_y[i] && qy < m_y[i] + OH) draw = 1;
      end
    end
    if (r) begin
      m_state = 0; m_score = 0; m_max = 0; m_timer = 0; m_lfsr = SEED; draw = 0;
      for (int i = 0; i < N; i++) begin m_v[i] = 0; m_x[i] = 0; m_y[i] = 0; end
    end else begin
      if (m_state == 0) draw = 0;
      rv = int'(m_lfsr);
      m_lfsr = {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
      if (m_state != 1) begin
        if (s) begin
          m_state = 1; m_score = 0; m_timer = 0;
          for (int i = 0; i < N; i++) m_v[i] = 0;
        end
      end else if (col) begin
        m_state = 2;
      end else if (t) begin
        stp = SINIT + m_score / SE;
        if (stp > SMAX) stp = SMAX;
        spawn = (m_timer == SD - 1);
        m_timer = spawn ? 0 : m_timer + 1;
        fi = -1;
        for (int i = 0; i < N; i++) if (m_v[i] == 0 && fi < 0) fi = i;
        add = 0;
        for (int i = 0; i < N; i++) begin
          if (m_v[i] != 0) begin
            if (m_y[i] + stp >= 480) begin m_v[i] = 0; add++; end
            else m_y[i] = m_y[i] + stp;
          end
        end
        if (spawn && fi >= 0) begin
          m_v[fi] = 1; m_y[fi] = 0; m_x[fi] = (rv >= 608) ? rv - 608 : rv;
        end
        m_score = m_score + add;
        if (m_score > SCORE_TOP) m_score = SCORE_TOP;
        if (m_score > m_max) m_max = m_score;
      end
    end
    @(posedge clk); #1;
    e.playing = (m_state == 1) ? 1 : 0;
    e.over    = (m_state == 2) ? 1 : 0;
    e.score   = m_score;
    e.maxs    = m_max;
    e.valid   = 0;
    for (int i = 0; i < N; i++) if (m_v[i] != 0) e.valid = e.valid | (1 << i);
    e.draw    = draw ? 1 : 0;
    exp_q.push_back(e);
  endtask

  // Aim the pixel probe at an inside corner, just past the right edge, or the top-left of a slot.
  task automatic set_probe(input int k, input int p);
    case (p)
      0:       begin bus.pix_x = 10'(m_x[k] + OW - 1); bus.pix_y = 10'(m_y[k] + OH - 1); end
      1:       begin bus.pix_x = 10'(m_x[k] + OW);     bus.pix_y = 10'(m_y[k]); end
      default: begin bus.pix_x = 10'(m_x[k]);          bus.pix_y = 10'(m_y[k]); end
    endcase
  endtask

  initial begin
    int n, extra, k;
    reset = 1'b1; bus.tick = 1'b0; bus.start = 1'b0;
    bus.player_x = 10'd700; bus.player_y = 10'd0;
    bus.pix_x = 10'd0; bus.pix_y = 10'd0;
    for (int i = 0; i < N; i++) begin m_v[i] = 0; m_x[i] = 0; m_y[i] = 0; end
    m_state = 0; m_score = 0; m_max = 0; m_timer = 0; m_lfsr = SEED;

    cyc(1, 0, 0); cyc(1, 1, 1);           // reset wins over start/tick
    cyc(0, 1, 0); cyc(0, 1, 0);           // tick ignored in IDLE
    cyc(0, 0, 1);                         // start -> PLAY
    cyc(0, 0, 1);                         // start ignored in PLAY

    // Player parked off-screen: obstacles spawn, fall, exit, speed up, score saturates.
    n = 0; extra = 0;
    while ((m_score < SCORE_TOP || extra < 300) && n < 20000) begin
      set_probe(n % N, (n / N) % 3);
      cyc(0, (n % 2) == 0, 0);
      n++;
      if (m_score == SCORE_TOP) extra++;
    end
    total++;
    if (m_score == SCORE_TOP) passed++;
    else begin failed++; $display("FAIL saturate_budget: score %0d after %0d cycles", m_score, n); end

    // Move the player under the highest obstacle and tick every cycle until it hits.
    k = -1;
    for (int i = 0; i < N; i++) if (m_v[i] != 0 && (k < 0 || m_y[i] < m_y[k])) k = i;
    if (k < 0) k = 0;
    bus.player_x = 10'(m_x[k]); bus.player_y = 10'd440;
    n = 0;
    while (m_state != 2 && n < 300) begin
      set_probe(k, n % 3);
      cyc(0, 1, 0);
      n++;
    end
    total++;
    if (m_state == 2) passed++;
    else begin failed++; $display("FAIL collision_budget: state %0d after %0d cycles", m_state, n); end
    for (int i = 0; i < 6; i++) begin
      set_probe(k, i % 3);
      cyc(0, 1, 0);                       // frozen in OVER, still drawn
    end

    // Restart keeps the best score.
    bus.player_x = 10'd700; bus.player_y = 10'd0;
    cyc(0, 0, 1);
    for (int i = 0; i < 12; i++) begin
      set_probe(0, i % 3);
      cyc(0, (i % 2) == 0, 0);
    end

    // Reset mid-game clears everything, including max_score.
    cyc(1, 0, 0);
    cyc(0, 1, 0); cyc(0, 0, 0);

    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() == 0) passed++;
    else begin failed++; $display("FAIL drain: %0d entries left", exp_q.size()); end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
